// File: rtl/operand_load_ctrl.sv
// Operand entry sequencer: debounces the confirm button into press strobes, issues the okA/okB loads, starts the ALU and waits for it.
// Optional abort of a stalled second-operand entry is built only when OPLOAD_TIMEOUT_EN is defined.
module operand_load_ctrl #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ok,
  input  logic       btn_clr,
  input  logic       alu_done,
  output logic       okA,
  output logic       okB,
  output logic       alu_start,
  output logic       busy,
  output logic       show_result,
  output logic [2:0] state,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GOT_A = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE);

  if (DEBOUNCE < 1 || TIMEOUT < 1) begin : g_param_check
    $error("operand_load_ctrl: DEBOUNCE and TIMEOUT must be at least 1");
  end

  state_t          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            press;
  logic            oka_q, oka_d, okb_q, okb_d, start_q, start_d;
  logic            timeout_q, to_fire, to_hit;

  // The flip happens in the cycle the counter sits at DEBOUNCE, whatever btn_ok does then.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press      = 1'b0;
    if (db_cnt_q == DB_MAX) begin
      db_level_d = ~db_level_q;
      press      = ~db_level_q;
    end else if (btn_ok != db_level_q) begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    oka_d   = 1'b0;
    okb_d   = 1'b0;
    start_d = 1'b0;
    to_fire = 1'b0;
    if (btn_clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (press) begin oka_d = 1'b1; state_d = S_GOT_A; end
        S_GOT_A: begin
          if (press) begin
            okb_d   = 1'b1;
            state_d = S_START;
          end else if (to_hit) begin
            to_fire = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_START: begin start_d = 1'b1; state_d = S_WAIT; end
        S_WAIT:  if (alu_done) state_d = S_SHOW;
        S_SHOW:  if (press) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      oka_q      <= 1'b0;
      okb_q      <= 1'b0;
      start_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      oka_q      <= oka_d;
      okb_q      <= okb_d;
      start_q    <= start_d;
      timeout_q  <= to_fire;
    end
  end

`ifdef OPLOAD_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts cycles spent in S_GOT_A; zero on the entry cycle and whenever the state is left.
  assign to_hit   = (to_cnt_q == TO_LAST);
  assign to_cnt_d = (state_q == S_GOT_A && state_d == S_GOT_A) ? to_cnt_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign okA         = oka_q;
  assign okB         = okb_q;
  assign alu_start   = start_q;
  assign timeout     = timeout_q;
  assign state       = state_q;
  assign busy        = (state_q == S_START) || (state_q == S_WAIT);
  assign show_result = (state_q == S_SHOW);

endmodule

// File: doc/operand_load_ctrl.md
Name: operand_load_ctrl

Overview:
- Sequences operand entry for the two-operand datapath: turns a debounced "OK" button into one-cycle load enables okA / okB for the operand register selectors, then starts the ALU and waits for completion.
- Sits between the board buttons and the operand registers and ALU. The operand value itself (num) goes straight to the selectors; this block only decides when each register loads.

Parameters:
- DEBOUNCE, 4: cycles btn_ok must be stable high (or low) before a press (or release) is accepted; minimum 1.
- TIMEOUT, 1000000: cycles allowed in S_GOT_A before abort; used only with OPLOAD_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_ok  in  1  raw confirm button, synchronised externally, may bounce.
- btn_clr  in  1  clear request, level-sensitive, already clean.
- alu_done  in  1  one-cycle pulse from the ALU: result valid.
- okA  out  1  one-cycle load enable for operand register A.
- okB  out  1  one-cycle load enable for operand register B.
- alu_start  out  1  one-cycle ALU start pulse.
- busy  out  1  high in S_START and S_WAIT.
- show_result  out  1  high in S_SHOW.
- state  out  3  current state encoding, for LEDs and debug.
- timeout  out  1  one-cycle abort pulse; constant 0 without the optional feature.

Behaviour:
- Reset: on the rising edge with rst=1, state=S_IDLE (0). okA, okB, alu_start, busy, show_result and timeout all go to 0. Debounce counter, debounced level and timeout counter clear. rst mid-operation aborts with no pulses.
- Debounce:
  - Counter increments while btn_ok differs from the debounced level and resets to 0 when they match.
  - When the counter reaches DEBOUNCE, the debounced level flips.
  - A 0->1 flip creates internal press, a one-cycle strobe in that same cycle.
  - Only one press per high period; the button must debounce low before another press is possible.
- States (encoding):
  - S_IDLE=0: on press, okA=1 for that cycle, go to S_GOT_A.
  - S_GOT_A=1: on press, okB=1 for that cycle, go to S_START.
  - S_START=2: alu_start=1 for one cycle, go to S_WAIT unconditionally.
  - S_WAIT=3: stay until alu_done=1, then go to S_SHOW. Presses are ignored.
  - S_SHOW=4: on press, go to S_IDLE with no load pulse. The next press loads A again.
  - Encodings 5-7 are illegal and go to S_IDLE on the next cycle.
- Output timing: okA, okB, alu_start and timeout are registered. Each is high exactly in the cycle after the qualifying edge and never longer than one cycle. okA and okB are never high together.
- Latency: btn_ok stable high from cycle 0 produces press and the okA pulse DEBOUNCE+1 cycles later.
- btn_clr:
  - Sampled every cycle; highest priority after rst.
  - Any state goes to S_IDLE with no pulses that cycle, even if a press or alu_done coincides.
  - The debounce state is kept, so a held button does not re-fire.
  - Operand registers are not cleared; they simply are not reloaded.
- alu_done outside S_WAIT is ignored.
- busy and show_result are decoded from the registered state and are glitch-free.

Optional Feature:
- Macro: OPLOAD_TIMEOUT_EN.
- Defined:
  - A counter runs while in S_GOT_A and clears on entry to S_GOT_A and on leaving it.
  - When it reaches TIMEOUT-1 with no press, the next edge goes to S_IDLE and timeout=1 for one cycle.
  - A press in that same cycle wins: okB fires and there is no timeout.
- Not defined: S_GOT_A waits forever, timeout is tied to 0 and no counter is built.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> state=0, all outputs 0. Hold rst=1 mid-S_WAIT -> state=0 next edge with no pulses.
- Full operation (DEBOUNCE=4):
  - Clean press of 10 cycles high -> okA pulses once, 5 cycles after rise, state=1.
  - Second press -> okB once, state=2 then 3, alu_start for 1 cycle.
  - alu_done pulse -> state=4, show_result=1.
  - Third press -> state=0.
- Bounce: btn_ok toggles 1,0,1,1,0,1,1,1,1,1 -> exactly one okA. Holding high for 50 cycles -> still one okA.
- Clear priority:
  - btn_clr=1 in the same cycle as the accepted second press -> okB=0, state=0.
  - btn_clr=1 in the same cycle as alu_done -> state=0, show_result stays 0.
- Stray done: alu_done in S_IDLE and S_GOT_A -> state unchanged. A press during S_WAIT -> no okA or okB.
- OPLOAD_TIMEOUT_EN, TIMEOUT=20:
  - No press after okA -> timeout pulse, 20 cycles after entering S_GOT_A, state=0.
  - Press accepted on the last cycle -> okB, no timeout.
  - Macro undefined -> after 100 idle cycles still state=1, timeout=0.
